rs_byte_framer: RTL

RS_BYTE_FRAMER -- requirements
Module: rs_byte_framer

---
 rtl/rs_byte_framer.sv | 87 ++++++++
 1 files changed

// File: rtl/rs_byte_framer.sv
// rs_byte_framer: edge-captured byte stream into a fall-through FIFO tagged with frame boundaries
// Ports:
//   clk, reset (async, active-low)
//   Rx_DATA/Rx_VALID       : receiver byte and level strobe (one byte per rising strobe)
//   out_data/out_valid/out_ready/out_last : FIFO head handshake, out_last marks frame end
//   ce_out, frame_done, frame_abort       : one-cycle event pulses
//   overflow (sticky), byte_idx (write-side frame index), fifo_level (occupancy)
module rs_byte_framer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 204,
  parameter int TIMEOUT    = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_W-1:0]              Rx_DATA,
  input  logic                           Rx_VALID,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           ce_out,
  output logic                           frame_done,
  output logic                           frame_abort,
  output logic                           overflow,
  output logic [$clog2(FRAME_LEN)-1:0]   byte_idx,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
  localparam int BW = $clog2(FRAME_LEN);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int IW = $clog2(TIMEOUT > 1 ? TIMEOUT : 2);
  localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_LEN - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic {WAIT, RECV} state_t;
  state_t st, nxt;
  logic [DATA_W:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] idle;
  logic rx_q, armed, cap, rd, wr, is_last, abort;
  // armed blocks a strobe that was already high when reset released
  assign cap = Rx_VALID & ~rx_q & armed;
  assign rd = out_valid & out_ready;
  // a same-edge pop frees the slot, so full only blocks when nothing is read
  assign wr = cap & ((fifo_level != DEPTH_L) | rd);
  assign is_last = byte_idx == LAST_IDX;
  assign out_valid = fifo_level != '0;
  assign out_data = out_valid ? mem[rd_ptr][DATA_W-1:0] : '0;
  assign out_last = out_valid & mem[rd_ptr][DATA_W];
  always_comb begin
    abort = st == RECV && !wr && TIMEOUT > 0 && idle == IDLE_MAX;
    nxt = st;
    if (st == WAIT) nxt = wr ? RECV : WAIT;
    else if ((wr && is_last) || abort) nxt = WAIT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st          <= WAIT;
      rx_q        <= 1'b0;
      armed       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      byte_idx    <= '0;
      idle        <= '0;
      ce_out      <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      st          <= nxt;
      rx_q        <= Rx_VALID;
      armed       <= armed | ~Rx_VALID;
      wr_ptr      <= wr ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr      <= rd ? rd_ptr + PW'(1) : rd_ptr;
      fifo_level  <= fifo_level + LW'(wr) - LW'(rd);
      byte_idx    <= abort ? '0 : wr ? (is_last ? '0 : byte_idx + BW'(1)) : byte_idx;
      idle        <= (st == RECV && !wr && !abort && TIMEOUT > 0) ? idle + IW'(1) : '0;
      ce_out      <= wr;
      frame_done  <= wr & is_last;
      frame_abort <= abort;
      overflow    <= overflow | (cap & ~wr);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= {is_last, Rx_DATA};
endmodule
